// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port round-robin arbiter/sequencer in front of the byte-addressed data RAM.
// Define RAM_ARB_CPU_PRIO_EN for fixed priority to port 0 (port 1 may starve).
module ram_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [1:0]        p0_mode,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic              p0_err,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [1:0]        p1_mode,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic              p1_err,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic [1:0]        ram_mode,
    output logic              ram_we,
    output logic              ram_sel,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy,
    output logic              owner
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t state, next;
    logic last, winner, any_req, grant, in_access, illegal;
    logic cur_we;
    logic [1:0] cur_mode;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata, rd;

    always_comb begin
        any_req = p0_req | p1_req;
`ifdef RAM_ARB_CPU_PRIO_EN
        winner = ~p0_req;
`else
        winner = (p0_req & p1_req) ? ~last : p1_req;
`endif
        grant = (state == IDLE || state == DONE) && any_req;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
            owner <= 1'b1;
            last  <= 1'b1;
        end else begin
            state <= next;
            if (grant) begin
                owner <= winner;
                last  <= winner;
            end
        end
    end

    always_comb begin
        next = (state == ACCESS) ? DONE : (grant ? ACCESS : IDLE);
    end

    always_comb begin
        cur_we    = owner ? p1_we    : p0_we;
        cur_mode  = owner ? p1_mode  : p0_mode;
        cur_addr  = owner ? p1_addr  : p0_addr;
        cur_wdata = owner ? p1_wdata : p0_wdata;
        illegal   = (cur_mode == 2'b11) || (cur_mode == 2'b10 && cur_addr[1:0] != 2'b00) ||
                    (cur_mode == 2'b01 && cur_addr[0]);
        in_access = state == ACCESS;
        ram_sel   = in_access & ~illegal;
        ram_we    = ram_sel & cur_we;
        ram_addr  = in_access ? cur_addr : '0;
        ram_din   = in_access ? cur_wdata : '0;
        ram_mode  = in_access ? cur_mode : 2'b00;
        busy      = state != IDLE;
        rd        = (ram_sel && !cur_we) ? ram_dout : '0;
    end

    // Completion is registered on the ACCESS edge so ack lines up with the DONE cycle.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            p0_ack   <= 1'b0;
            p0_err   <= 1'b0;
            p0_rdata <= '0;
            p1_ack   <= 1'b0;
            p1_err   <= 1'b0;
            p1_rdata <= '0;
        end else begin
            p0_ack <= in_access & ~owner;
            p0_err <= in_access & ~owner & illegal;
            p1_ack <= in_access & owner;
            p1_err <= in_access & owner & illegal;
            if (in_access && !owner) p0_rdata <= rd;
            if (in_access && owner) p1_rdata <= rd;
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter with a little-endian byte RAM model.
module tb_ram_arbiter;
`ifdef RAM_ARB_CPU_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif
    logic clk = 1'b0;
    logic clr_n;
    logic p0_req, p0_we, p0_ack, p0_err, p1_req, p1_we, p1_ack, p1_err;
    logic [1:0] p0_mode, p1_mode, ram_mode;
    logic [11:0] p0_addr, p1_addr, ram_addr, a1, a2, a3;
    logic [31:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, ram_din, ram_dout;
    logic ram_we, ram_sel, busy, owner;
    logic [7:0] mem [0:4095];
    int total = 0;
    int bad = 0;
    logic t_sel, t_ack, t_err, t_oack;
    logic [31:0] t_rdata;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk(clk), .clr_n(clr_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_mode(p0_mode), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_mode(p1_mode), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_mode(ram_mode), .ram_we(ram_we),
        .ram_sel(ram_sel), .ram_dout(ram_dout), .busy(busy), .owner(owner)
    );

    assign a1 = ram_addr + 12'd1;
    assign a2 = ram_addr + 12'd2;
    assign a3 = ram_addr + 12'd3;

    always @(posedge clk) begin
        if (ram_sel && ram_we) begin
            mem[ram_addr] <= ram_din[7:0];
            if (ram_mode != 2'b00) mem[a1] <= ram_din[15:8];
            if (ram_mode == 2'b10) begin
                mem[a2] <= ram_din[23:16];
                mem[a3] <= ram_din[31:24];
            end
        end
    end

    always_comb begin
        ram_dout = (ram_mode == 2'b00) ? {24'h0, mem[ram_addr]} :
                   (ram_mode == 2'b01) ? {16'h0, mem[a1], mem[ram_addr]} :
                                         {mem[a3], mem[a2], mem[a1], mem[ram_addr]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input bit p, input bit rq, input bit we, input logic [1:0] md,
                            input logic [11:0] a, input logic [31:0] wd);
        if (p) begin
            p1_req = rq; p1_we = we; p1_mode = md; p1_addr = a; p1_wdata = wd;
        end else begin
            p0_req = rq; p0_we = we; p0_mode = md; p0_addr = a; p0_wdata = wd;
        end
    endtask

    // Starts one cycle after a rising edge; returns one cycle after the DONE edge.
    task automatic txn(input bit p, input bit we, input logic [1:0] md,
                       input logic [11:0] a, input logic [31:0] wd);
        set_port(p, 1'b1, we, md, a, wd);
        @(posedge clk); #1;
        chk("txn_busy", {31'b0, busy}, 32'd1);
        chk("txn_owner", {31'b0, owner}, {31'b0, p});
        t_sel = ram_sel;
        @(posedge clk); #1;
        t_ack   = p ? p1_ack : p0_ack;
        t_err   = p ? p1_err : p0_err;
        t_rdata = p ? p1_rdata : p0_rdata;
        t_oack  = p ? p0_ack : p1_ack;
        set_port(p, 1'b0, we, md, a, wd);
        @(posedge clk); #1;
    endtask

    initial begin
        clr_n = 1'b0;
        set_port(0, 0, 0, 2'b00, 12'h0, 32'h0);
        set_port(1, 0, 0, 2'b00, 12'h0, 32'h0);
        @(posedge clk); #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_owner", {31'b0, owner}, 32'd1);
        chk("rst_acks", {30'b0, p0_ack, p1_ack}, 32'd0);
        chk("rst_rdata", p0_rdata | p1_rdata, 32'd0);
        chk("rst_ram", {ram_sel, ram_we, ram_mode, ram_addr} | ram_din, 32'd0);
        clr_n = 1'b1;

        txn(0, 1, 2'b10, 12'h010, 32'hDEADBEEF);
        chk("w0_ack", {31'b0, t_ack}, 32'd1);
        chk("w0_err", {31'b0, t_err}, 32'd0);
        chk("w0_sel", {31'b0, t_sel}, 32'd1);
        chk("w0_rdata", t_rdata, 32'd0);
        txn(0, 0, 2'b10, 12'h010, 32'h0);
        chk("r0_ack", {31'b0, t_ack}, 32'd1);
        chk("r0_rdata", t_rdata, 32'hDEADBEEF);
        chk("r0_p1ack", {31'b0, t_oack}, 32'd0);

        txn(1, 1, 2'b00, 12'h013, 32'h000000AB);
        chk("wb1_ack", {31'b0, t_ack}, 32'd1);
        txn(1, 0, 2'b00, 12'h013, 32'h0);
        chk("rb1_rdata", t_rdata, 32'h000000AB);
        txn(0, 0, 2'b10, 12'h010, 32'h0);
        chk("rw0_merge", t_rdata, 32'hABADBEEF);
        chk("p1_rdata_held", p1_rdata, 32'h000000AB);

        txn(0, 1, 2'b10, 12'h000, 32'h11223344);
        txn(0, 1, 2'b10, 12'h002, 32'h55555555);
        chk("mis_ack", {31'b0, t_ack}, 32'd1);
        chk("mis_err", {31'b0, t_err}, 32'd1);
        chk("mis_sel", {31'b0, t_sel}, 32'd0);
        chk("mis_rdata", t_rdata, 32'd0);
        txn(0, 0, 2'b10, 12'h000, 32'h0);
        chk("mis_unchanged", t_rdata, 32'h11223344);
        chk("ok_err", {31'b0, t_err}, 32'd0);

        txn(0, 1, 2'b01, 12'h006, 32'h00001234);
        txn(0, 0, 2'b01, 12'h006, 32'h0);
        chk("half_rdata", t_rdata, 32'h00001234);
        txn(0, 0, 2'b11, 12'h008, 32'h0);
        chk("mode3_err", {31'b0, t_err}, 32'd1);
        chk("mode3_sel", {31'b0, t_sel}, 32'd0);
        txn(1, 1, 2'b11, 12'h020, 32'h0);
        chk("mode3_p1_err", {31'b0, t_err}, 32'd1);
        txn(0, 0, 2'b01, 12'h007, 32'h0);
        chk("half_odd_err", {31'b0, t_err}, 32'd1);

        txn(1, 1, 2'b10, 12'h020, 32'hCAFEF00D);
        set_port(1, 1, 1, 2'b10, 12'h020, 32'h12345678);
        @(posedge clk); #1;
        chk("rst_mid_sel_pre", {31'b0, ram_sel}, 32'd1);
        clr_n = 1'b0;
        #1;
        chk("rst_mid_sel", {31'b0, ram_sel}, 32'd0);
        chk("rst_mid_we", {31'b0, ram_we}, 32'd0);
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        chk("rst_mid_owner", {31'b0, owner}, 32'd1);
        chk("rst_mid_addr", {20'b0, ram_addr}, 32'd0);
        chk("rst_mid_rdata", p0_rdata | p1_rdata, 32'd0);
        set_port(1, 0, 0, 2'b10, 12'h020, 32'h0);
        @(posedge clk); #1;
        chk("rst_mid_ack", {30'b0, p0_ack, p1_ack}, 32'd0);
        clr_n = 1'b1;

        set_port(0, 1, 0, 2'b10, 12'h010, 32'h0);
        set_port(1, 1, 0, 2'b10, 12'h020, 32'h0);
        for (int i = 0; i < 4; i++) begin
            bit e;
            e = PRIO ? 1'b0 : i[0];
            @(posedge clk); #1;
            chk("tie_owner", {31'b0, owner}, {31'b0, e});
            chk("tie_access_ack", {30'b0, p0_ack, p1_ack}, 32'd0);
            @(posedge clk); #1;
            chk("tie_acks", {30'b0, p0_ack, p1_ack}, e ? 32'd1 : 32'd2);
            chk("tie_rdata", e ? p1_rdata : p0_rdata, e ? 32'hCAFEF00D : 32'hABADBEEF);
        end
        set_port(0, 0, 0, 2'b10, 12'h010, 32'h0);
        set_port(1, 0, 0, 2'b10, 12'h020, 32'h0);
        @(posedge clk); #1;
        chk("final_idle", {31'b0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
